// File: rtl/tl_master_port_if.sv
// rtl/tl_master_port_if.sv - TileLink-UL/UH channel A and D signal bundle
interface tilelink;
  // Channel A (initiator to slave)
  logic        a_valid;
  logic        a_ready;
  logic [2:0]  a_opcode;
  logic [2:0]  a_param;
  logic [2:0]  a_size;
  logic [7:0]  a_source;
  logic [63:0] a_address;
  logic [7:0]  a_mask;
  logic [63:0] a_data;
  logic        a_corrupt;
  // Channel D (slave to initiator)
  logic        d_valid;
  logic        d_ready;
  logic [2:0]  d_opcode;
  logic [1:0]  d_param;
  logic [2:0]  d_size;
  logic [7:0]  d_source;
  logic        d_sink;
  logic        d_denied;
  logic [63:0] d_data;
  logic        d_corrupt;

  modport master (
    output a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, a_corrupt,
    input  a_ready,
    input  d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_data, d_corrupt,
    output d_ready
  );

  modport slave (
    input  a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, a_corrupt,
    output a_ready,
    output d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_data, d_corrupt,
    input  d_ready
  );
endinterface

// File: rtl/tl_master_port.sv
// rtl/tl_master_port.sv - single-outstanding TileLink-UL/UH initiator (optional TL_MASTER_TIMEOUT_EN)
module tl_master_port #(
  parameter logic [7:0]  SOURCE_ID = 8'd0,
  parameter int unsigned TIMEOUT   = 1024
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [2:0]  i_req_op,
  input  logic [2:0]  i_req_param,
  input  logic [2:0]  i_req_size,
  input  logic        i_req_unsigned,
  input  logic [63:0] i_req_addr,
  input  logic [63:0] i_req_wdata,
  input  logic [7:0]  i_req_wmask,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [63:0] o_rsp_rdata,
  output logic        o_rsp_error,
  tilelink.master     bus
);

  // TileLink channel-A opcodes
  localparam logic [2:0] TL_PUT_F = 3'd0;
  localparam logic [2:0] TL_PUT_P = 3'd1;
  localparam logic [2:0] TL_ARITH = 3'd2;
  localparam logic [2:0] TL_LOGIC = 3'd3;
  localparam logic [2:0] TL_GET   = 3'd4;
  // Channel-D opcode carrying data
  localparam logic [2:0] TL_ACK_DATA = 3'd1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next;

  // Latched request, already translated into channel-A form
  logic [2:0]  r_opcode;
  logic [2:0]  r_param;
  logic [2:0]  r_size;
  logic        r_unsigned;
  logic        r_is_put;
  logic [63:0] r_addr;
  logic [63:0] r_wdata;
  logic [7:0]  r_mask;

  logic [63:0] r_rsp_rdata;
  logic        r_rsp_error;

  logic [7:0]  w_size_mask;
  logic [2:0]  w_off_mask;
  logic        w_misaligned;
  logic [2:0]  w_opcode;
  logic        w_is_atomic;
  logic        w_is_put;
  logic [7:0]  w_mask;
  logic        w_beat_ok;
  logic        w_timeout;
  logic [63:0] w_shifted;
  logic        w_sign;
  logic [63:0] w_ext;
  logic [63:0] w_beat_rdata;
  logic        w_accept;
  logic        w_a_fire;

  // D-channel fields that carry nothing this initiator acts on
  logic        w_unused_d;
  assign w_unused_d = ^{bus.d_param, bus.d_size, bus.d_sink, bus.d_denied, bus.d_corrupt};

  // Byte-lane mask and alignment check derived from the requested size
  always_comb begin
    w_size_mask = 8'h01;
    w_off_mask  = 3'b000;
    case (i_req_size[1:0])
      2'd1: begin w_size_mask = 8'h03; w_off_mask = 3'b001; end
      2'd2: begin w_size_mask = 8'h0F; w_off_mask = 3'b011; end
      2'd3: begin w_size_mask = 8'hFF; w_off_mask = 3'b111; end
      default: begin w_size_mask = 8'h01; w_off_mask = 3'b000; end
    endcase
    // Sizes above 8 bytes cannot be carried on a 64-bit beat, so reject them too
    w_misaligned = i_req_size[2] | (|(i_req_addr[2:0] & w_off_mask));
  end

  // Core op code to TileLink opcode; reserved codes behave as a Get
  always_comb begin
    w_opcode    = TL_GET;
    w_is_atomic = 1'b0;
    w_is_put    = 1'b0;
    case (i_req_op)
      3'd1: begin w_opcode = TL_PUT_F; w_is_put = 1'b1; end
      3'd2: begin w_opcode = TL_PUT_P; w_is_put = 1'b1; end
      3'd3: begin w_opcode = TL_ARITH; w_is_atomic = 1'b1; end
      3'd4: begin w_opcode = TL_LOGIC; w_is_atomic = 1'b1; end
      default: begin w_opcode = TL_GET; end
    endcase
    w_mask = (i_req_op == 3'd2) ? (i_req_wmask & w_size_mask) : w_size_mask;
  end

  // Read-data alignment: bring the addressed lanes to bit 0, then extend
  always_comb begin
    w_shifted = bus.d_data >> {r_addr[2:0], 3'b000};
    w_sign    = 1'b0;
    w_ext     = w_shifted;
    case (r_size[1:0])
      2'd0: begin
        w_sign = ~r_unsigned & w_shifted[7];
        w_ext  = {{56{w_sign}}, w_shifted[7:0]};
      end
      2'd1: begin
        w_sign = ~r_unsigned & w_shifted[15];
        w_ext  = {{48{w_sign}}, w_shifted[15:0]};
      end
      2'd2: begin
        w_sign = ~r_unsigned & w_shifted[31];
        w_ext  = {{32{w_sign}}, w_shifted[31:0]};
      end
      default: w_ext = w_shifted;
    endcase
    w_beat_rdata = (r_is_put || (bus.d_opcode != TL_ACK_DATA)) ? 64'd0 : w_ext;
  end

  assign w_beat_ok = bus.d_valid & (bus.d_source == SOURCE_ID);
  assign w_accept  = (r_state == S_IDLE) & i_req_valid;
  assign w_a_fire  = (r_state == S_REQ) & bus.a_ready;

`ifdef TL_MASTER_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);
  logic [15:0] r_wait_cnt;

  // Cycles spent in WAIT for the current transaction
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wait_cnt <= 16'd0;
    end else if (w_a_fire) begin
      r_wait_cnt <= 16'd0;
    end else if (r_state == S_WAIT) begin
      r_wait_cnt <= r_wait_cnt + 16'd1;
    end
  end

  assign w_timeout = (r_state == S_WAIT) & (r_wait_cnt == TIMEOUT_LAST);
`else
  localparam int unsigned unused_timeout = TIMEOUT;
  assign w_timeout = 1'b0;
`endif

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and handshake outputs
  always_comb begin
    w_next      = r_state;
    o_req_ready = 1'b0;
    bus.a_valid = 1'b0;
    bus.d_ready = 1'b0;
    o_rsp_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_req_ready = 1'b1;
        if (i_req_valid) begin
          w_next = w_misaligned ? S_RESP : S_REQ;
        end
      end
      S_REQ: begin
        bus.a_valid = 1'b1;
        if (bus.a_ready) begin
          w_next = S_WAIT;
        end
      end
      S_WAIT: begin
        bus.d_ready = 1'b1;
        if (w_beat_ok || w_timeout) begin
          w_next = S_RESP;
        end
      end
      S_RESP: begin
        o_rsp_valid = 1'b1;
        if (i_rsp_ready) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Request latch and response capture
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_opcode    <= 3'd0;
      r_param     <= 3'd0;
      r_size      <= 3'd0;
      r_unsigned  <= 1'b0;
      r_is_put    <= 1'b0;
      r_addr      <= 64'd0;
      r_wdata     <= 64'd0;
      r_mask      <= 8'd0;
      r_rsp_rdata <= 64'd0;
      r_rsp_error <= 1'b0;
    end else begin
      if (w_accept) begin
        if (w_misaligned) begin
          r_rsp_rdata <= 64'd0;
          r_rsp_error <= 1'b1;
        end else begin
          r_opcode    <= w_opcode;
          r_param     <= w_is_atomic ? i_req_param : 3'd0;
          r_size      <= i_req_size;
          r_unsigned  <= i_req_unsigned;
          r_is_put    <= w_is_put;
          r_addr      <= i_req_addr;
          r_wdata     <= i_req_wdata;
          r_mask      <= w_mask;
          r_rsp_rdata <= 64'd0;
          r_rsp_error <= 1'b0;
        end
      end else if (r_state == S_WAIT) begin
        // An accepted beat wins over a timeout landing in the same cycle
        if (w_beat_ok) begin
          r_rsp_rdata <= w_beat_rdata;
          r_rsp_error <= 1'b0;
        end else if (w_timeout) begin
          r_rsp_rdata <= 64'd0;
          r_rsp_error <= 1'b1;
        end
      end
    end
  end

  assign bus.a_opcode  = r_opcode;
  assign bus.a_param   = r_param;
  assign bus.a_size    = r_size;
  assign bus.a_source  = SOURCE_ID;
  assign bus.a_address = r_addr;
  assign bus.a_mask    = r_mask;
  assign bus.a_data    = r_wdata;
  assign bus.a_corrupt = 1'b0;

  assign o_rsp_rdata = r_rsp_rdata;
  assign o_rsp_error = r_rsp_error;

endmodule
